// File: rtl/stack_calc.sv
// Stack calculator: top-of-stack register plus a synchronous RAM holding the
// elements below it. Ops that need the second (or a deeper) element read the
// RAM at the accept edge and finish one cycle later in EXEC; all other ops
// finish at the accept edge.
module stack_calc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    cnt,
    output logic             err,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = (WIDTH > CW) ? WIDTH : CW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    localparam logic [3:0] OP_PUSH  = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_NEG   = 4'd5;
    localparam logic [3:0] OP_GT    = 4'd6;
    localparam logic [3:0] OP_SWAP  = 4'd7;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_DUP   = 4'd9;
    localparam logic [3:0] OP_CLEAR = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Elements below top; element i from the bottom lives at address i.
    logic [WIDTH-1:0] mem [DEPTH-1];

    logic [WIDTH-1:0] rdata_p1;
    logic [3:0]       op_p1;
    logic [3:0]       op_nxt;

    logic [WIDTH-1:0] out_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             err_nxt;
    logic             done_nxt;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    raddr;
    logic             go_exec;

    logic [LW-1:0]    k_w;
    logic [LW-1:0]    sec_w;
    logic             load_ok;

    // Signed-positive test of the top element, as a WIDTH-bit 0/1 value.
    function automatic logic [WIDTH-1:0] gt_flag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] zero_s;
        zero_s = '0;
        return {{(WIDTH-1){1'b0}}, (v > zero_s)};
    endfunction

    // Two's-complement negation, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_wrap(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] zero_s;
        zero_s = '0;
        return zero_s - v;
    endfunction

    // LOAD depth check: k = out must not reach below the bottom element.
    always_comb begin
        k_w     = LW'(out);
        sec_w   = LW'(cnt - TWO);
        load_ok = (cnt >= TWO) && (k_w <= sec_w);
    end

    // Next-state and datapath decode; ready only while idle.
    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        cnt_nxt   = cnt;
        err_nxt   = err;
        done_nxt  = 1'b0;
        op_nxt    = op_p1;
        we        = 1'b0;
        waddr     = AW'(cnt - ONE);
        wdata     = out;
        re        = 1'b0;
        raddr     = AW'(cnt - TWO);
        go_exec   = 1'b0;
        ready     = (state == IDLE);

        case (state)
            IDLE: begin
                if (valid) begin
                    done_nxt = 1'b1;
                    case (op)
                        OP_PUSH: begin
                            if (cnt == FULL) begin
                                err_nxt = 1'b1;
                            end else begin
                                we      = (cnt != '0);
                                out_nxt = d;
                                cnt_nxt = cnt + ONE;
                            end
                        end
                        OP_POP: begin
                            if (cnt == '0) begin
                                err_nxt = 1'b1;
                            end else if (cnt == ONE) begin
                                out_nxt = '0;
                                cnt_nxt = '0;
                            end else begin
                                go_exec = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
                            if (cnt < TWO) err_nxt = 1'b1;
                            else           go_exec = 1'b1;
                        end
                        OP_NEG: begin
                            if (cnt == '0) err_nxt = 1'b1;
                            else           out_nxt = neg_wrap(out);
                        end
                        OP_GT: begin
                            if (cnt == '0) err_nxt = 1'b1;
                            else           out_nxt = gt_flag(out);
                        end
                        OP_LOAD: begin
                            if (!load_ok) begin
                                err_nxt = 1'b1;
                            end else begin
                                go_exec = 1'b1;
                                raddr   = AW'(sec_w - k_w);
                            end
                        end
                        OP_DUP: begin
                            if (cnt == '0 || cnt == FULL) begin
                                err_nxt = 1'b1;
                            end else begin
                                we      = 1'b1;
                                cnt_nxt = cnt + ONE;
                            end
                        end
                        OP_CLEAR: begin
                            out_nxt = '0;
                            cnt_nxt = '0;
                            err_nxt = 1'b0;
                        end
                        default: err_nxt = 1'b1;
                    endcase

                    if (go_exec) begin
                        re        = 1'b1;
                        op_nxt    = op;
                        state_nxt = EXEC;
                        done_nxt  = 1'b0;
                    end
                end
            end

            EXEC: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                case (op_p1)
                    OP_POP: begin
                        out_nxt = rdata_p1;
                        cnt_nxt = cnt - ONE;
                    end
                    OP_ADD: begin
                        out_nxt = rdata_p1 + out;
                        cnt_nxt = cnt - ONE;
                    end
                    OP_SUB: begin
                        out_nxt = rdata_p1 - out;
                        cnt_nxt = cnt - ONE;
                    end
                    OP_MUL: begin
                        out_nxt = rdata_p1 * out;
                        cnt_nxt = cnt - ONE;
                    end
                    OP_SWAP: begin
                        out_nxt = rdata_p1;
                        we      = 1'b1;
                        waddr   = AW'(cnt - TWO);
                        wdata   = out;
                    end
                    OP_LOAD: out_nxt = rdata_p1;
                    default: ;
                endcase
            end

            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Architectural state: top, count, sticky error, completion pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            op_p1 <= OP_PUSH;
        end else begin
            out   <= out_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
            done  <= done_nxt;
            op_p1 <= op_nxt;
        end
    end

    // Stack RAM, synchronous read and write; writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (we && nrst) mem[waddr] <= wdata;
        if (re)         rdata_p1 <= mem[raddr];
    end

endmodule

// File: tb/tb_stack_calc.sv
// Directed testbench for stack_calc, built with a small stack (DEPTH=8) so
// the overflow boundary is reachable quickly.
module tb_stack_calc;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [3:0] OP_PUSH  = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_NEG   = 4'd5;
    localparam logic [3:0] OP_GT    = 4'd6;
    localparam logic [3:0] OP_SWAP  = 4'd7;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_DUP   = 4'd9;
    localparam logic [3:0] OP_CLEAR = 4'd10;

    logic             clk;
    logic             nrst;
    logic             valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] d;
    logic             ready;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    cnt;
    logic             err;
    logic             done;

    int vec  = 0;
    int miss = 0;
    int lat;
    logic r1;

    stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .valid(valid), .op(op), .d(d),
        .ready(ready), .out(out), .cnt(cnt), .err(err), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from a negedge; returns the number of negedges until done
    // (-1 if it never came) and the ready value one negedge after accept.
    task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] v,
                         output int l, output logic rdy1);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        valid = 1'b1; op = o; d = v;
        @(posedge clk);
        #1;
        valid = 1'b0; op = 4'd0; d = '0;
        l = -1;
        rdy1 = 1'bx;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) rdy1 = ready;
            if (done === 1'b1) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; valid = 1'b0; op = 4'd0; d = '0;
        repeat (3) @(negedge clk);
        vec++; if (out !== 16'h0)   begin miss++; $display("FAIL reset_out got %0h want 0", out); end
        vec++; if (cnt !== 4'd0)    begin miss++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        vec++; if (err !== 1'b0)    begin miss++; $display("FAIL reset_err got %b want 0", err); end
        vec++; if (done !== 1'b0)   begin miss++; $display("FAIL reset_done got %b want 0", done); end
        vec++; if (ready !== 1'b1)  begin miss++; $display("FAIL reset_ready got %b want 1", ready); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        issue(OP_PUSH, 16'd5, lat, r1);
        vec++; if (lat !== 1) begin miss++; $display("FAIL push_latency got %0d want 1", lat); end
        issue(OP_PUSH, 16'd7, lat, r1);
        issue(OP_ADD, 16'd0, lat, r1);
        vec++; if (lat !== 2)       begin miss++; $display("FAIL add_latency got %0d want 2", lat); end
        vec++; if (r1 !== 1'b0)     begin miss++; $display("FAIL add_ready_low got %b want 0", r1); end
        vec++; if (ready !== 1'b1)  begin miss++; $display("FAIL add_ready_back got %b want 1", ready); end
        vec++; if (out !== 16'd12)  begin miss++; $display("FAIL add_out got %0d want 12", out); end
        vec++; if (cnt !== 4'd1)    begin miss++; $display("FAIL add_cnt got %0d want 1", cnt); end
        vec++; if (err !== 1'b0)    begin miss++; $display("FAIL add_err got %b want 0", err); end
        issue(OP_PUSH, 16'd3, lat, r1);
        issue(OP_SUB, 16'd0, lat, r1);
        vec++; if (out !== 16'd9)   begin miss++; $display("FAIL sub_out got %0d want 9", out); end
        issue(OP_PUSH, 16'd4, lat, r1);
        issue(OP_MUL, 16'd0, lat, r1);
        vec++; if (out !== 16'd36)  begin miss++; $display("FAIL mul_out got %0d want 36", out); end
        issue(OP_PUSH, 16'h1000, lat, r1);
        issue(OP_MUL, 16'd0, lat, r1);
        vec++; if (out !== 16'h4000) begin miss++; $display("FAIL mul_wrap got %0h want 4000", out); end
        vec++; if (cnt !== 4'd1)     begin miss++; $display("FAIL mul_cnt got %0d want 1", cnt); end
        issue(OP_PUSH, 16'd5, lat, r1);
        issue(OP_SUB, 16'd0, lat, r1);
        vec++; if (out !== 16'h3FFB) begin miss++; $display("FAIL sub_pos got %0h want 3ffb", out); end
    endtask

    task automatic test_swap();
        issue(OP_CLEAR, 16'd0, lat, r1);
        issue(OP_PUSH, 16'd3, lat, r1);
        issue(OP_PUSH, 16'd9, lat, r1);
        issue(OP_SWAP, 16'd0, lat, r1);
        vec++; if (lat !== 2)       begin miss++; $display("FAIL swap_latency got %0d want 2", lat); end
        vec++; if (out !== 16'd3)   begin miss++; $display("FAIL swap_out got %0d want 3", out); end
        vec++; if (cnt !== 4'd2)    begin miss++; $display("FAIL swap_cnt got %0d want 2", cnt); end
        issue(OP_POP, 16'd0, lat, r1);
        vec++; if (lat !== 2)       begin miss++; $display("FAIL pop_latency got %0d want 2", lat); end
        vec++; if (out !== 16'd9)   begin miss++; $display("FAIL pop_out got %0d want 9", out); end
        vec++; if (cnt !== 4'd1)    begin miss++; $display("FAIL pop_cnt got %0d want 1", cnt); end
    endtask

    task automatic test_overflow();
        issue(OP_CLEAR, 16'd0, lat, r1);
        for (int i = 1; i <= DEPTH; i++) issue(OP_PUSH, WIDTH'(i), lat, r1);
        vec++; if (cnt !== 4'd8)    begin miss++; $display("FAIL full_cnt got %0d want 8", cnt); end
        vec++; if (err !== 1'b0)    begin miss++; $display("FAIL full_err got %b want 0", err); end
        issue(OP_PUSH, 16'd1, lat, r1);
        vec++; if (lat !== 1)       begin miss++; $display("FAIL ovf_latency got %0d want 1", lat); end
        vec++; if (cnt !== 4'd8)    begin miss++; $display("FAIL ovf_cnt got %0d want 8", cnt); end
        vec++; if (out !== 16'd8)   begin miss++; $display("FAIL ovf_out got %0d want 8", out); end
        vec++; if (err !== 1'b1)    begin miss++; $display("FAIL ovf_err got %b want 1", err); end
        issue(OP_DUP, 16'd0, lat, r1);
        vec++; if (cnt !== 4'd8)    begin miss++; $display("FAIL dup_ovf_cnt got %0d want 8", cnt); end
        issue(OP_POP, 16'd0, lat, r1);
        vec++; if (out !== 16'd7)   begin miss++; $display("FAIL full_pop_out got %0d want 7", out); end
        vec++; if (err !== 1'b1)    begin miss++; $display("FAIL err_sticky got %b want 1", err); end
        issue(OP_CLEAR, 16'd0, lat, r1);
        vec++; if (cnt !== 4'd0)    begin miss++; $display("FAIL clear_cnt got %0d want 0", cnt); end
        vec++; if (out !== 16'd0)   begin miss++; $display("FAIL clear_out got %0d want 0", out); end
        vec++; if (err !== 1'b0)    begin miss++; $display("FAIL clear_err got %b want 0", err); end
    endtask

    task automatic test_underflow();
        issue(OP_ADD, 16'd0, lat, r1);
        vec++; if (lat !== 1)       begin miss++; $display("FAIL unf_latency got %0d want 1", lat); end
        vec++; if (err !== 1'b1)    begin miss++; $display("FAIL unf_err got %b want 1", err); end
        vec++; if (cnt !== 4'd0)    begin miss++; $display("FAIL unf_cnt got %0d want 0", cnt); end
        vec++; if (out !== 16'd0)   begin miss++; $display("FAIL unf_out got %0d want 0", out); end
        issue(OP_PUSH, 16'd5, lat, r1);
        issue(OP_POP, 16'd0, lat, r1);
        vec++; if (lat !== 1)       begin miss++; $display("FAIL pop1_latency got %0d want 1", lat); end
        vec++; if (out !== 16'd0)   begin miss++; $display("FAIL pop1_out got %0d want 0", out); end
        vec++; if (cnt !== 4'd0)    begin miss++; $display("FAIL pop1_cnt got %0d want 0", cnt); end
        vec++; if (err !== 1'b1)    begin miss++; $display("FAIL pop1_err got %b want 1", err); end
        issue(OP_CLEAR, 16'd0, lat, r1);
        issue(OP_PUSH, 16'd6, lat, r1);
        issue(4'd12, 16'd0, lat, r1);
        vec++; if (err !== 1'b1)    begin miss++; $display("FAIL illegal_err got %b want 1", err); end
        vec++; if (out !== 16'd6)   begin miss++; $display("FAIL illegal_out got %0d want 6", out); end
        vec++; if (cnt !== 4'd1)    begin miss++; $display("FAIL illegal_cnt got %0d want 1", cnt); end
        issue(OP_SWAP, 16'd0, lat, r1);
        vec++; if (out !== 16'd6)   begin miss++; $display("FAIL swap1_out got %0d want 6", out); end
    endtask

    task automatic test_load();
        issue(OP_CLEAR, 16'd0, lat, r1);
        issue(OP_PUSH, 16'd10, lat, r1);
        issue(OP_PUSH, 16'd20, lat, r1);
        issue(OP_PUSH, 16'd30, lat, r1);
        issue(OP_PUSH, 16'd1, lat, r1);
        issue(OP_LOAD, 16'd0, lat, r1);
        vec++; if (lat !== 2)       begin miss++; $display("FAIL load_latency got %0d want 2", lat); end
        vec++; if (out !== 16'd20)  begin miss++; $display("FAIL load_out got %0d want 20", out); end
        vec++; if (cnt !== 4'd4)    begin miss++; $display("FAIL load_cnt got %0d want 4", cnt); end
        vec++; if (err !== 1'b0)    begin miss++; $display("FAIL load_err got %b want 0", err); end
        issue(OP_PUSH, 16'd4, lat, r1);
        issue(OP_LOAD, 16'd0, lat, r1);
        vec++; if (err !== 1'b1)    begin miss++; $display("FAIL load_deep_err got %b want 1", err); end
        vec++; if (cnt !== 4'd5)    begin miss++; $display("FAIL load_deep_cnt got %0d want 5", cnt); end
        vec++; if (out !== 16'd4)   begin miss++; $display("FAIL load_deep_out got %0d want 4", out); end
        issue(OP_CLEAR, 16'd0, lat, r1);
        issue(OP_PUSH, 16'd10, lat, r1);
        issue(OP_PUSH, 16'd20, lat, r1);
        issue(OP_PUSH, 16'd30, lat, r1);
        issue(OP_PUSH, 16'd2, lat, r1);
        issue(OP_LOAD, 16'd0, lat, r1);
        vec++; if (out !== 16'd10)  begin miss++; $display("FAIL load_bottom got %0d want 10", out); end
    endtask

    task automatic test_neg_gt_dup();
        issue(OP_CLEAR, 16'd0, lat, r1);
        issue(OP_PUSH, 16'h8000, lat, r1);
        issue(OP_NEG, 16'd0, lat, r1);
        vec++; if (out !== 16'h8000) begin miss++; $display("FAIL neg_min got %0h want 8000", out); end
        issue(OP_GT, 16'd0, lat, r1);
        vec++; if (out !== 16'd0)    begin miss++; $display("FAIL gt_neg got %0h want 0", out); end
        issue(OP_PUSH, 16'd3, lat, r1);
        issue(OP_NEG, 16'd0, lat, r1);
        vec++; if (out !== 16'hFFFD) begin miss++; $display("FAIL neg3 got %0h want fffd", out); end
        issue(OP_PUSH, 16'd5, lat, r1);
        issue(OP_GT, 16'd0, lat, r1);
        vec++; if (out !== 16'd1)    begin miss++; $display("FAIL gt_pos got %0h want 1", out); end
        issue(OP_PUSH, 16'd7, lat, r1);
        issue(OP_DUP, 16'd0, lat, r1);
        vec++; if (cnt !== 4'd5)     begin miss++; $display("FAIL dup_cnt got %0d want 5", cnt); end
        vec++; if (out !== 16'd7)    begin miss++; $display("FAIL dup_out got %0d want 7", out); end
        issue(OP_POP, 16'd0, lat, r1);
        vec++; if (out !== 16'd7)    begin miss++; $display("FAIL dup_pop got %0d want 7", out); end
        vec++; if (err !== 1'b0)     begin miss++; $display("FAIL neg_gt_err got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        issue(OP_CLEAR, 16'd0, lat, r1);
        issue(OP_PUSH, 16'd1, lat, r1);
        issue(OP_PUSH, 16'd2, lat, r1);
        valid = 1'b1; op = OP_ADD; d = '0;
        @(posedge clk);
        #1;
        op = OP_PUSH; d = 16'd99;
        @(posedge clk);
        #1;
        valid = 1'b0; op = 4'd0; d = '0;
        @(negedge clk);
        vec++; if (done !== 1'b1)   begin miss++; $display("FAIL b2b_done got %b want 1", done); end
        vec++; if (out !== 16'd3)   begin miss++; $display("FAIL b2b_out got %0d want 3", out); end
        vec++; if (cnt !== 4'd1)    begin miss++; $display("FAIL b2b_cnt got %0d want 1", cnt); end
        @(negedge clk);
        vec++; if (done !== 1'b0)   begin miss++; $display("FAIL b2b_noqueue got %b want 0", done); end
        vec++; if (cnt !== 4'd1)    begin miss++; $display("FAIL b2b_cnt2 got %0d want 1", cnt); end
    endtask

    task automatic test_reset_exec();
        issue(OP_CLEAR, 16'd0, lat, r1);
        issue(OP_PUSH, 16'd3, lat, r1);
        issue(OP_PUSH, 16'd4, lat, r1);
        valid = 1'b1; op = OP_MUL; d = '0;
        @(posedge clk);
        #1;
        valid = 1'b0; op = 4'd0;
        @(negedge clk);
        vec++; if (ready !== 1'b0)  begin miss++; $display("FAIL mul_exec_ready got %b want 0", ready); end
        nrst = 1'b0;
        #1;
        vec++; if (out !== 16'd0)   begin miss++; $display("FAIL rst_exec_out got %0d want 0", out); end
        vec++; if (cnt !== 4'd0)    begin miss++; $display("FAIL rst_exec_cnt got %0d want 0", cnt); end
        vec++; if (ready !== 1'b1)  begin miss++; $display("FAIL rst_exec_ready got %b want 1", ready); end
        @(negedge clk);
        vec++; if (done !== 1'b0)   begin miss++; $display("FAIL rst_exec_done got %b want 0", done); end
        nrst = 1'b1;
        @(negedge clk);
        issue(OP_PUSH, 16'd2, lat, r1);
        vec++; if (out !== 16'd2)   begin miss++; $display("FAIL post_rst_out got %0d want 2", out); end
        vec++; if (cnt !== 4'd1)    begin miss++; $display("FAIL post_rst_cnt got %0d want 1", cnt); end
        vec++; if (err !== 1'b0)    begin miss++; $display("FAIL post_rst_err got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_swap();
        test_overflow();
        test_underflow();
        test_load();
        test_neg_gt_dup();
        test_back_to_back();
        test_reset_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/stack_calc.md
STACK_CALC -- requirements
Module: stack_calc

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; legal range 4 to 64.
REQ-002 Parameter DEPTH, default 1024: maximum number of stack elements including top; power of two, at least 4.
REQ-003 Parameter CW, default $clog2(DEPTH)+1: width of cnt.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 valid  input  1  op request; accepted when valid && ready at a rising edge.
REQ-007 op  input  4  opcode, decoded per REQ-012.
REQ-008 d  input  WIDTH  push operand.
REQ-009 ready  output  1  unit can accept an op this cycle.
REQ-010 out  output  WIDTH  top of stack; 0 when empty.
REQ-011 cnt  output  CW  current element count, 0..DEPTH; err  output  1  sticky error flag; done  output  1  one-cycle pulse on op completion.

Function
REQ-012 Opcodes SHALL be 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 NEG, 6 GT, 7 SWAP, 8 LOAD, 9 DUP, 10 CLEAR, 11-15 illegal.
REQ-013 Top SHALL live in register out; elements below top SHALL live in a DEPTH-1 x WIDTH RAM, synchronous read and write, with element i from the bottom at address i and the second element at cnt-2.
REQ-014 FSM SHALL have states IDLE and EXEC; ready=1 only in IDLE.
REQ-015 Single-cycle ops (PUSH, NEG, GT, DUP, CLEAR, illegal, POP with cnt<=1, any erroring op) SHALL complete at the accept edge: FSM stays IDLE, done=1 the following cycle.
REQ-016 RAM-reading ops (POP with cnt>=2, ADD, SUB, MUL, SWAP, LOAD) SHALL issue the read at the accept edge, enter EXEC, and update at the next edge, returning to IDLE; done=1 the cycle after that edge (latency 2).
REQ-017 PUSH SHALL write out to RAM address cnt-1 when cnt>=1, then set out<=d and cnt<=cnt+1.
REQ-018 DUP SHALL write out to RAM address cnt-1 and increment cnt, leaving out unchanged.
REQ-019 POP SHALL set out<=second element and decrement cnt; with cnt==1 it SHALL set out<=0 and cnt<=0.
REQ-020 ADD, SUB and MUL SHALL set out<=second+top, second-top and low WIDTH bits of second*top respectively, modulo 2^WIDTH, and decrement cnt.
REQ-021 NEG SHALL set out<=two's-complement negation, mod 2^WIDTH; GT SHALL set out<=1 if out is signed-positive, else 0.
REQ-022 SWAP SHALL exchange top and second: read address cnt-2 on accept; in EXEC, out<=rdata and RAM[cnt-2]<=old out; cnt unchanged.
REQ-023 LOAD SHALL replace out with the element k=out positions below top (k=0 means second), i.e. RAM[cnt-2-k]; cnt unchanged.
REQ-024 CLEAR SHALL set cnt<=0, out<=0 and err<=0.
REQ-025 Overflow: PUSH or DUP with cnt==DEPTH SHALL be ignored and set err.
REQ-026 Underflow: POP with cnt==0, or ADD/SUB/MUL/SWAP with cnt<2, or NEG/GT/DUP/LOAD with cnt==0, SHALL be ignored and set err.
REQ-027 LOAD with k>cnt-2 SHALL be ignored and set err; illegal opcodes SHALL set err with no other effect.
REQ-028 Ignored ops SHALL leave out, cnt and RAM unchanged, and SHALL still produce done.
REQ-029 err SHALL stay set until CLEAR or reset.
REQ-030 valid while ready=0 SHALL be ignored and not queued; d and op are only sampled at the accept edge.

Reset
REQ-031 nrst low SHALL immediately force out=0, cnt=0, err=0, done=0, FSM=IDLE and ready=1, aborting any EXEC op with no RAM write.
REQ-032 RAM contents SHALL NOT be reset; all reads are gated by cnt, so stale data is never observable.

Verification
REQ-033 Reset, PUSH 5, PUSH 7, ADD -> out=12, cnt=1, done 2 cycles after the ADD accept, ready low 1 cycle.
REQ-034 PUSH 3, PUSH 9, SWAP, POP -> after SWAP out=3 and cnt=2; after POP out=9, cnt=1.
REQ-035 Push DEPTH values, then PUSH 1 -> cnt=DEPTH, out unchanged, err=1; CLEAR -> cnt=0, out=0, err=0.
REQ-036 Empty stack, ADD -> err=1, cnt=0, out=0; POP with cnt==1 -> out=0, cnt=0, err unchanged.
REQ-037 PUSH 10,20,30, PUSH 1, LOAD -> out=20; then PUSH 4, LOAD -> err=1, cnt=5, out=4.
REQ-038 PUSH 0x8000, NEG, GT at WIDTH=16 -> NEG gives 0x8000, GT gives 0; nrst pulsed during MUL EXEC -> out=0, cnt=0, ready=1.
